// File: rtl/soluzione.sv
// ============================================================================
// soluzione: two-digit ten's-complement BCD to 7-bit two's-complement binary.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module soluzione (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] A10,
    output logic [6:0] A2,
    output logic       err
);

    logic [3:0] w_d1;
    logic [3:0] w_d0;
    logic       w_bad;
    logic [6:0] w_mag;
    logic [6:0] a2_d;
    logic       err_d;
    logic [6:0] a2_q;
    logic       err_q;

    assign w_d1  = A10[7:4];
    assign w_d0  = A10[3:0];
    assign w_bad = (w_d1 > 4'd9) || (w_d0 > 4'd9);

    // 10*d1 as 8*d1 + 2*d1; wraps only for non-BCD digits, which are masked below
    assign w_mag = {w_d1, 3'b000} + {2'b00, w_d1, 1'b0} + {3'b000, w_d0};

    // V - 100 is congruent to V + 28 modulo 128
    always_comb begin
        a2_d  = 7'd0;
        err_d = 1'b0;
        if (w_bad) begin
            err_d = 1'b1;
        end else if (w_d1 >= 4'd5) begin
            a2_d = w_mag + 7'd28;
        end else begin
            a2_d = w_mag;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a2_q  <= 7'd0;
            err_q <= 1'b0;
        end else begin
            a2_q  <= a2_d;
            err_q <= err_d;
        end
    end

    assign A2  = a2_q;
    assign err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_soluzione.sv
// ============================================================================
// tb_soluzione: directed self-checking bench for soluzione.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_soluzione;

    logic       clock;
    logic       reset;
    logic [7:0] A10;
    logic [6:0] A2;
    logic       err;

    int checks   = 0;
    int failures = 0;

    soluzione dut (
        .clock (clock),
        .reset (reset),
        .A10   (A10),
        .A2    (A2),
        .err   (err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [6:0] exp_a2, input logic exp_err);
        checks++;
        assert (A2 === exp_a2) else begin
            failures++;
            $error("FAIL %s A2 observed=%b expected=%b", tag, A2, exp_a2);
        end
        checks++;
        assert (err === exp_err) else begin
            failures++;
            $error("FAIL %s err observed=%b expected=%b", tag, err, exp_err);
        end
    endtask

    // Drive A10 on the falling edge, sample 1 time unit after the next rising edge
    task automatic apply(input logic [7:0] a);
        @(negedge clock);
        A10 = a;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int v;
        logic [6:0] e;
        logic [7:0] code;

        reset = 1'b1;
        A10   = 8'h77;
        #1;
        check("reset_state", 7'd0, 1'b0);
        @(posedge clock);
        #1;
        check("reset_held_over_edge", 7'd0, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        apply(8'h05); check("h05", 7'b000_0101, 1'b0);
        apply(8'h15); check("h15", 7'b000_1111, 1'b0);
        apply(8'h99); check("h99", 7'b111_1111, 1'b0);
        apply(8'h69); check("h69", 7'b110_0001, 1'b0);
        apply(8'h50); check("h50", 7'b100_1110, 1'b0);
        apply(8'h49); check("h49", 7'b011_0001, 1'b0);
        apply(8'h00); check("h00", 7'b000_0000, 1'b0);
        apply(8'h3A); check("h3A", 7'b000_0000, 1'b1);
        apply(8'h12); check("h12", 7'b000_1100, 1'b0);
        apply(8'hA0); check("hA0", 7'b000_0000, 1'b1);

        // Asynchronous reset between edges with -1 loaded
        apply(8'h99); check("pre_reset_h99", 7'b111_1111, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 7'd0, 1'b0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("first_edge_after_reset", 7'b111_1111, 1'b0);

        // Input changes between edges must not reach the outputs
        apply(8'h12); check("h12_again", 7'b000_1100, 1'b0);
        #2;
        A10 = 8'h05;
        #1;
        check("hold_between_edges", 7'b000_1100, 1'b0);
        A10 = 8'h30;
        @(posedge clock);
        #1;
        check("h30_after_change", 7'b001_1110, 1'b0);

        // Full sweep against an integer model
        for (int i = 0; i < 256; i++) begin
            code = i[7:0];
            apply(code);
            if (code[7:4] > 4'd9 || code[3:0] > 4'd9) begin
                check("sweep_invalid", 7'd0, 1'b1);
            end else begin
                v = 10 * int'(code[7:4]) + int'(code[3:0]);
                if (code[7:4] >= 4'd5) v = v - 100;
                e = v[6:0];
                check("sweep_valid", e, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/soluzione.md
SOLUZIONE -- requirements
Module: Soluzione

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL be fixed as listed below.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with the ports listed below.
REQ-003 clock  input  1  Single clock; all state updates on the rising edge.
REQ-004 reset  input  1  Asynchronous, active-high reset.
REQ-005 A10  input  8  Two BCD digits in ten's-complement form: A10[7:4] = tens digit d1, A10[3:0] = units digit d0.
REQ-006 A2  output  7  Two's-complement binary value of A10, registered.
REQ-007 err  output  1  Registered flag; 1 when the sampled A10 contains a non-BCD digit (nibble > 9).

Function
REQ-008 Magnitude code SHALL be V = 10*d1 + d0, with range 0..99.
REQ-009 The number represented SHALL be V when d1 <= 4 (range 0..+49).
REQ-010 The number represented SHALL be V - 100 when d1 >= 5 (range -50..-1).
REQ-011 A2 SHALL hold the represented number as 7-bit two's complement; the full range -50..+49 fits, so no overflow case exists.
REQ-012 On each rising clock edge with reset low, A2 and err SHALL load the conversion of the A10 value present at that edge (latency 1 cycle, throughput 1 conversion per cycle).
REQ-013 The conversion path from A10 to the register inputs SHALL be purely combinational, with no internal multi-cycle sequencing.
REQ-014 If either nibble of A10 is greater than 9, the next edge SHALL load err = 1 and A2 = 7'b000_0000.
REQ-015 For valid input, the next edge SHALL load err = 0.
REQ-016 Boundary: A10 = 8'h49 SHALL give A2 = +49 = 7'b011_0001.
REQ-017 Boundary: A10 = 8'h50 SHALL give A2 = -50 = 7'b100_1110.
REQ-018 Boundary: A10 = 8'h00 SHALL give A2 = 7'b000_0000.
REQ-019 A2 and err SHALL change only on a rising clock edge or on assertion of reset; changes on A10 between edges SHALL have no effect on the outputs.

Reset
REQ-020 While reset = 1, A2 SHALL be 7'b000_0000 and err SHALL be 0, immediately and independent of clock.
REQ-021 Reset asserted between clock edges SHALL clear the outputs at once, discarding the pending conversion.
REQ-022 After reset deasserts, the first rising edge SHALL load the conversion of the current A10.

Verification
REQ-023 Reset, then A10 = 8'h05, one edge -> A2 = 7'b000_0101 (+5), err = 0.
REQ-024 A10 = 8'h15, one edge -> A2 = 7'b000_1111 (+15); then A10 = 8'h99, one edge -> A2 = 7'b111_1111 (-1).
REQ-025 A10 = 8'h69, one edge -> A2 = 7'b110_0001 (-31); A10 = 8'h50, one edge -> A2 = 7'b100_1110 (-50).
REQ-026 A10 = 8'h49 -> A2 = 7'b011_0001; A10 = 8'h3A, one edge -> err = 1, A2 = 0; next edge with A10 = 8'h12 -> err = 0, A2 = 7'b000_1100.
REQ-027 With A2 = -1 loaded, assert reset mid-cycle -> A2 = 0 and err = 0 before the next edge; change A10 between edges -> outputs hold until the next edge.
REQ-028 Exhaustive sweep of all 100 valid BCD codes SHALL match REQ-008 to REQ-011.
REQ-029 Sweep of all 156 invalid codes SHALL give err = 1 and A2 = 0.
